stage2_memory_access: RTL and testbench

//  Stage-2 memory-access block of the JALA 16-bit stack CPU. It holds a dual-port,

---
 rtl/stage2_memory_access_pkg.sv | 29 ++
 rtl/stage2_memory_access_dual_port_ram.sv | 65 ++++++
 rtl/stage2_memory_access.sv | 110 +++++++++++
 tb/tb_stage2_memory_access.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/stage2_memory_access_pkg.sv
// Shared definitions for the JALA stage-2 memory-access slice:
// mux-select encodings and default widths.
package stage2_memory_access_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 13;

    typedef enum logic [1:0] {
        DST1_PC       = 2'd0,
        DST1_MSP      = 2'd1,
        DST1_VALA     = 2'd2,
        DST1_VALA_ALT = 2'd3
    } memDst1Sel_e;

    typedef enum logic [1:0] {
        DST2_MSP      = 2'd0,
        DST2_RSP      = 2'd1,
        DST2_VALA     = 2'd2,
        DST2_VALA_ALT = 2'd3
    } memDst2Sel_e;

    typedef enum logic [1:0] {
        DATA_PC    = 2'd0,
        DATA_RES   = 2'd1,
        DATA_ZEIMM = 2'd2,
        DATA_VALB  = 2'd3
    } memDataSel_e;

endpackage

// File: rtl/stage2_memory_access_dual_port_ram.sv
// Dual-port word-addressed RAM: two independent read-first R/W ports with
// registered read data. Power-up content is i % 10; contents survive reset.
module dual_port_ram #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] wrData1,
    input  logic [DATA_W-1:0] wrData2,
    input  logic              read1,
    input  logic              read2,
    input  logic              write1,
    input  logic              write2,
    output logic [DATA_W-1:0] rdData1,
    output logic [DATA_W-1:0] rdData2
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] words_s [DEPTH];
    logic [DATA_W-1:0] rdLatch1_r;
    logic [DATA_W-1:0] rdLatch2_r;

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        logic [DATA_W-1:0] word_r = DATA_W'(i % 10);

        // Word storage: held (not cleared) during reset; port 2 wins a same-address collision
        always_ff @(posedge CLK or negedge Reset_n) begin
            if (!Reset_n) begin
                word_r <= word_r;
            end else if (write2 && (addr2 == ADDR_W'(i))) begin
                word_r <= wrData2;
            end else if (write1 && (addr1 == ADDR_W'(i))) begin
                word_r <= wrData1;
            end
        end

        assign words_s[i] = word_r;
    end

    // Port-1 read latch: samples the pre-edge word, so a same-edge write is not seen
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            rdLatch1_r <= {DATA_W{1'b0}};
        end else if (read1) begin
            rdLatch1_r <= words_s[addr1];
        end
    end

    // Port-2 read latch
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            rdLatch2_r <= {DATA_W{1'b0}};
        end else if (read2) begin
            rdLatch2_r <= words_s[addr2];
        end
    end

    assign rdData1 = rdLatch1_r;
    assign rdData2 = rdLatch2_r;

endmodule

// File: rtl/stage2_memory_access.sv
// JALA stage-2 memory access: address/data muxes in front of the dual-port
// memory, and the IR/ValA/ValB capture registers behind it.
module stage2_memory_access
    import stage2_memory_access_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              Reset_n,
    input  logic [1:0]        MemDst1,
    input  logic [1:0]        MemDst2,
    input  logic [1:0]        MemData,
    input  logic [15:0]       MemDst1FromPC,
    input  logic [15:0]       MemDst1FromMSP,
    input  logic [15:0]       MemDst2FromMSP,
    input  logic [15:0]       MemDst2FromRSP,
    input  logic [DATA_W-1:0] MemDataFromPC,
    input  logic [DATA_W-1:0] MemDataFromRes,
    input  logic [DATA_W-1:0] MemDataFromZEImm,
    input  logic              MemRead1,
    input  logic              MemRead2,
    input  logic              MemWrite1,
    input  logic              MemWrite2,
    input  logic              IRWrite,
    input  logic              ValBWrite,
    input  logic              ValAWrite,
    output logic [DATA_W-1:0] IR,
    output logic [DATA_W-1:0] ValA,
    output logic [DATA_W-1:0] ValB
);

    logic [ADDR_W-1:0] addr1_s;
    logic [ADDR_W-1:0] addr2_s;
    logic [DATA_W-1:0] wrData_s;
    logic [DATA_W-1:0] rdData1_s;
    logic [DATA_W-1:0] rdData2_s;

    // Port-1 address mux; upper address bits are dropped so addresses alias modulo depth
    always_comb begin
        addr1_s = MemDst1FromPC[ADDR_W-1:0];
        case (MemDst1)
            DST1_PC:                  addr1_s = MemDst1FromPC[ADDR_W-1:0];
            DST1_MSP:                 addr1_s = MemDst1FromMSP[ADDR_W-1:0];
            DST1_VALA, DST1_VALA_ALT: addr1_s = ValA[ADDR_W-1:0];
            default:                  addr1_s = MemDst1FromPC[ADDR_W-1:0];
        endcase
    end

    // Port-2 address mux
    always_comb begin
        addr2_s = MemDst2FromMSP[ADDR_W-1:0];
        case (MemDst2)
            DST2_MSP:                 addr2_s = MemDst2FromMSP[ADDR_W-1:0];
            DST2_RSP:                 addr2_s = MemDst2FromRSP[ADDR_W-1:0];
            DST2_VALA, DST2_VALA_ALT: addr2_s = ValA[ADDR_W-1:0];
            default:                  addr2_s = MemDst2FromMSP[ADDR_W-1:0];
        endcase
    end

    // Shared write-data mux feeding both ports
    always_comb begin
        wrData_s = MemDataFromPC;
        case (MemData)
            DATA_PC:    wrData_s = MemDataFromPC;
            DATA_RES:   wrData_s = MemDataFromRes;
            DATA_ZEIMM: wrData_s = MemDataFromZEImm;
            DATA_VALB:  wrData_s = ValB;
            default:    wrData_s = MemDataFromPC;
        endcase
    end

    dual_port_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .CLK     (CLK),
        .Reset_n (Reset_n),
        .addr1   (addr1_s),
        .addr2   (addr2_s),
        .wrData1 (wrData_s),
        .wrData2 (wrData_s),
        .read1   (MemRead1),
        .read2   (MemRead2),
        .write1  (MemWrite1),
        .write2  (MemWrite2),
        .rdData1 (rdData1_s),
        .rdData2 (rdData2_s)
    );

    // Capture registers: second stage of the two-clock address-to-register path
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            IR   <= {DATA_W{1'b0}};
            ValA <= {DATA_W{1'b0}};
            ValB <= {DATA_W{1'b0}};
        end else begin
            if (IRWrite) begin
                IR <= rdData1_s;
            end
            if (ValBWrite) begin
                ValB <= rdData1_s;
            end
            if (ValAWrite) begin
                ValA <= rdData2_s;
            end
        end
    end

endmodule

// File: tb/tb_stage2_memory_access.sv
// Scoreboard bench for stage2_memory_access: a behavioural memory model
// predicts IR/ValA/ValB per edge; a monitor compares at the falling edge.
module tb_stage2_memory_access;

    logic        CLK = 1'b0;
    logic        Reset_n = 1'b1;
    logic [1:0]  MemDst1, MemDst2, MemData;
    logic [15:0] MemDst1FromPC, MemDst1FromMSP, MemDst2FromMSP, MemDst2FromRSP;
    logic [15:0] MemDataFromPC, MemDataFromRes, MemDataFromZEImm;
    logic        MemRead1, MemRead2, MemWrite1, MemWrite2;
    logic        IRWrite, ValBWrite, ValAWrite;
    logic [15:0] IR, ValA, ValB;

    always #5 CLK = ~CLK;

    stage2_memory_access dut (
        .CLK(CLK), .Reset_n(Reset_n),
        .MemDst1(MemDst1), .MemDst2(MemDst2), .MemData(MemData),
        .MemDst1FromPC(MemDst1FromPC), .MemDst1FromMSP(MemDst1FromMSP),
        .MemDst2FromMSP(MemDst2FromMSP), .MemDst2FromRSP(MemDst2FromRSP),
        .MemDataFromPC(MemDataFromPC), .MemDataFromRes(MemDataFromRes),
        .MemDataFromZEImm(MemDataFromZEImm),
        .MemRead1(MemRead1), .MemRead2(MemRead2),
        .MemWrite1(MemWrite1), .MemWrite2(MemWrite2),
        .IRWrite(IRWrite), .ValBWrite(ValBWrite), .ValAWrite(ValAWrite),
        .IR(IR), .ValA(ValA), .ValB(ValB)
    );

    typedef struct {
        logic        rst_n;
        logic [1:0]  d1, d2, md;
        logic [15:0] pc, msp1, msp2, rsp, dpc, res, imm;
        logic        r1, r2, w1, w2, irw, vbw, vaw;
    } stim_t;

    typedef struct {
        int          cyc;
        logic [15:0] ir, va, vb;
    } exp_t;

    stim_t       st;
    exp_t        expQ[$];
    int          testsRun = 0;
    int          testsFailed = 0;
    int          edgeCnt = 0;

    // Reference model: plain word array plus the two read latches and the three registers
    logic [15:0] mMem [8192];
    logic [15:0] mL1 = 16'd0, mL2 = 16'd0, mIr = 16'd0, mVa = 16'd0, mVb = 16'd0;

    function automatic int wrapAddr(input logic [15:0] a);
        return int'(a) % 8192;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", name, edgeCnt, act, exp);
        end
    endtask

    task automatic idle();
        st = '{rst_n: 1'b1, d1: 2'd0, d2: 2'd0, md: 2'd0, pc: 16'd0, msp1: 16'd0,
               msp2: 16'd0, rsp: 16'd0, dpc: 16'd0, res: 16'd0, imm: 16'd0,
               r1: 1'b0, r2: 1'b0, w1: 1'b0, w2: 1'b0, irw: 1'b0, vbw: 1'b0, vaw: 1'b0};
    endtask

    // Drive one cycle's inputs, advance the model across the coming edge, queue the prediction
    task automatic step();
        int a1, a2;
        logic [15:0] wd, nL1, nL2;
        @(negedge CLK);
        #2;
        Reset_n = st.rst_n;
        MemDst1 = st.d1; MemDst2 = st.d2; MemData = st.md;
        MemDst1FromPC = st.pc; MemDst1FromMSP = st.msp1;
        MemDst2FromMSP = st.msp2; MemDst2FromRSP = st.rsp;
        MemDataFromPC = st.dpc; MemDataFromRes = st.res; MemDataFromZEImm = st.imm;
        MemRead1 = st.r1; MemRead2 = st.r2; MemWrite1 = st.w1; MemWrite2 = st.w2;
        IRWrite = st.irw; ValBWrite = st.vbw; ValAWrite = st.vaw;
        if (!st.rst_n) begin
            mL1 = 16'd0; mL2 = 16'd0; mIr = 16'd0; mVa = 16'd0; mVb = 16'd0;
        end else begin
            a1 = (st.d1 == 2'd0) ? wrapAddr(st.pc)   : (st.d1 == 2'd1) ? wrapAddr(st.msp1) : wrapAddr(mVa);
            a2 = (st.d2 == 2'd0) ? wrapAddr(st.msp2) : (st.d2 == 2'd1) ? wrapAddr(st.rsp)  : wrapAddr(mVa);
            wd = (st.md == 2'd0) ? st.dpc : (st.md == 2'd1) ? st.res : (st.md == 2'd2) ? st.imm : mVb;
            nL1 = st.r1 ? mMem[a1] : mL1;
            nL2 = st.r2 ? mMem[a2] : mL2;
            if (st.irw) mIr = mL1;
            if (st.vbw) mVb = mL1;
            if (st.vaw) mVa = mL2;
            mL1 = nL1;
            mL2 = nL2;
            if (st.w1) mMem[a1] = wd;
            if (st.w2) mMem[a2] = wd;
        end
        expQ.push_back('{cyc: edgeCnt + 1, ir: mIr, va: mVa, vb: mVb});
    endtask

    // Monitor: after each rising edge, compare the DUT registers with queued predictions
    initial begin
        forever begin
            @(posedge CLK);
            edgeCnt++;
            @(negedge CLK);
            while (expQ.size() > 0 && expQ[0].cyc <= edgeCnt) begin
                exp_t e;
                e = expQ.pop_front();
                check("IR", IR, e.ir);
                check("ValA", ValA, e.va);
                check("ValB", ValB, e.vb);
            end
        end
    end

    // Reset monitor: registers must clear as soon as reset asserts, without a clock edge
    initial begin
        forever begin
            @(negedge Reset_n);
            #1;
            check("async_rst_IR", IR, 16'd0);
            check("async_rst_ValA", ValA, 16'd0);
            check("async_rst_ValB", ValB, 16'd0);
        end
    end

    initial begin
        for (int i = 0; i < 8192; i++) mMem[i] = 16'(i % 10);
        idle();
        #3 Reset_n = 1'b0;
        st.rst_n = 1'b0;
        repeat (2) step();
        idle();
        step();

        // 1: IR from PC, ValA from MSP
        for (int k = 0; k < 19; k++) begin
            idle();
            st.d1 = 2'd0; st.d2 = 2'd0; st.r1 = 1'b1; st.r2 = 1'b1;
            st.irw = 1'b1; st.vaw = 1'b1;
            st.pc = 16'(19 - k); st.msp2 = 16'(k);
            step();
        end
        // 2: ValB from MSP1 while IR holds
        for (int k = 1; k < 20; k++) begin
            idle();
            st.d1 = 2'd1; st.r1 = 1'b1; st.vbw = 1'b1; st.msp1 = 16'(k);
            step();
        end
        // 3: store Res=255 at RSP=255, read it into ValA, load ValB=8
        idle(); st.d2 = 2'd1; st.rsp = 16'd255; st.md = 2'd1; st.res = 16'd255; st.w2 = 1'b1; step();
        idle(); st.d2 = 2'd0; st.msp2 = 16'd255; st.r2 = 1'b1; st.vaw = 1'b1; step(); step();
        idle(); st.d1 = 2'd1; st.msp1 = 16'd8; st.r1 = 1'b1; st.vbw = 1'b1; step(); step();
        // 4: store ValB at address ValA, read back through both ports
        idle(); st.d2 = 2'd2; st.md = 2'd3; st.w2 = 1'b1; step();
        idle(); st.d2 = 2'd2; st.r2 = 1'b1; st.vaw = 1'b1; step(); step();
        idle(); st.d1 = 2'd2; st.r1 = 1'b1; st.vbw = 1'b1; step(); step();
        // 5: wide data values at scattered addresses
        idle(); st.d2 = 2'd0; st.msp2 = 16'd495; st.md = 2'd1; st.res = 16'd25555; st.w2 = 1'b1; step();
        idle(); st.d1 = 2'd1; st.msp1 = 16'd495; st.r1 = 1'b1; st.vbw = 1'b1; step(); step();
        idle(); st.d2 = 2'd1; st.rsp = 16'd4839; st.md = 2'd0; st.dpc = 16'd6800; st.w2 = 1'b1; step();
        idle(); st.d1 = 2'd1; st.msp1 = 16'd4839; st.r1 = 1'b1; st.vbw = 1'b1; step(); step();
        // Address aliasing and read-first on a same-edge write
        idle(); st.d1 = 2'd0; st.pc = 16'd8197; st.r1 = 1'b1; st.irw = 1'b1; step(); step();
        idle(); st.d1 = 2'd0; st.pc = 16'd42; st.r1 = 1'b1; st.w1 = 1'b1; st.md = 2'd2;
        st.imm = 16'd777; st.irw = 1'b1; step();
        idle(); st.irw = 1'b1; step();
        idle(); st.d1 = 2'd0; st.pc = 16'd42; st.r1 = 1'b1; st.irw = 1'b1; step(); step();
        // 6: reset in the middle of a sweep, then continue; memory must be intact
        for (int k = 0; k < 12; k++) begin
            idle();
            st.r1 = 1'b1; st.r2 = 1'b1; st.irw = 1'b1; st.vaw = 1'b1;
            st.pc = 16'(495 + k); st.msp2 = 16'(250 + k);
            st.rst_n = (k == 5 || k == 6) ? 1'b0 : 1'b1;
            step();
        end
        // Same-address write on both ports
        idle(); st.pc = 16'd300; st.msp2 = 16'd300; st.w1 = 1'b1; st.w2 = 1'b1;
        st.md = 2'd2; st.imm = 16'd4321; step();
        idle(); st.pc = 16'd300; st.r1 = 1'b1; st.irw = 1'b1; step(); step();

        // Randomised traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            st.rst_n = ($urandom_range(0, 39) != 0);
            st.d1 = 2'($urandom_range(0, 3)); st.d2 = 2'($urandom_range(0, 3));
            st.md = 2'($urandom_range(0, 3));
            st.pc   = $urandom_range(0, 1) ? 16'($urandom_range(0, 31)) : 16'($urandom);
            st.msp1 = $urandom_range(0, 1) ? 16'($urandom_range(0, 31)) : 16'($urandom);
            st.msp2 = $urandom_range(0, 1) ? 16'($urandom_range(0, 31)) : 16'($urandom);
            st.rsp  = $urandom_range(0, 1) ? 16'($urandom_range(0, 31)) : 16'($urandom);
            st.dpc = 16'($urandom); st.res = 16'($urandom); st.imm = 16'($urandom);
            st.r1 = 1'($urandom_range(0, 1)); st.r2 = 1'($urandom_range(0, 1));
            st.w1 = ($urandom_range(0, 3) == 0); st.w2 = ($urandom_range(0, 3) == 0);
            st.irw = 1'($urandom_range(0, 1)); st.vbw = 1'($urandom_range(0, 1));
            st.vaw = 1'($urandom_range(0, 1));
            step();
        end

        idle();
        step();
        repeat (3) @(negedge CLK);
        #1;
        testsRun++;
        if (expQ.size() != 0) begin
            testsFailed++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
